mem_accumulator: RTL and testbench



---
 rtl/mem_accumulator_pkg.sv | 16 +
 rtl/mem_accumulator.sv | 128 ++++++++++++
 tb/tb_mem_accumulator.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/mem_accumulator_pkg.sv
// Shared widths and state encoding for the memory reduction stage.
package mem_accumulator_pkg;

    localparam int DEF_DATA_W    = 8;
    localparam int DEF_MEM_W     = 32;
    localparam int DEF_ACC_W     = 16;
    localparam int DEF_MEM_DEPTH = 256;
    localparam int ADDR_W        = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/mem_accumulator.sv
// Walks len consecutive words of the operand memory starting at base and
// sums the low DATA_W bits of each into an ACC_W accumulator.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | waiting for start; base/len latched on the start edge
//   RUN   | one word accumulated per clock, cnt counts down to 1
//   DONE  | one-cycle done pulse, sum/overflow already updated
module mem_accumulator
    import mem_accumulator_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int MEM_W     = DEF_MEM_W,
    parameter int MEM_DEPTH = DEF_MEM_DEPTH,
    parameter int ACC_W     = DEF_ACC_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base,
    input  logic [ADDR_W-1:0] len,
    output logic              busy,
    output logic              done,
    output logic [ACC_W-1:0]  sum,
    output logic              overflow
);

    // Preloaded from outside through a stable hierarchical path; never reset.
    logic [MEM_W-1:0] mem [MEM_DEPTH];

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic              acc_ovf_q, acc_ovf_d;
    logic [ACC_W-1:0]  sum_q, sum_d;
    logic              ovf_q, ovf_d;

    logic [MEM_W-1:0]  word;
    logic [DATA_W-1:0] operand;
    logic [ACC_W:0]    acc_ext;
    logic              unused_hi;
    logic              last_word;

    // Operand is read combinationally, so a mid-run memory write is summed
    // if it lands on the word currently addressed.
    assign word      = mem[addr_q];
    assign operand   = word[DATA_W-1:0];
    assign unused_hi = ^word[MEM_W-1:DATA_W];
    assign acc_ext   = {1'b0, acc_q} + {{(ACC_W + 1 - DATA_W){1'b0}}, operand};
    assign last_word = (cnt_q == ADDR_W'(1));

    // State and datapath registers, synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            cnt_q     <= '0;
            acc_q     <= '0;
            acc_ovf_q <= 1'b0;
            sum_q     <= '0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            acc_ovf_q <= acc_ovf_d;
            sum_q     <= sum_d;
            ovf_q     <= ovf_d;
        end
    end

    // Next-state decode.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (start) state_d = (len == '0) ? DONE : RUN;
            RUN:  if (last_word) state_d = DONE;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath next values: latch on start, accumulate in RUN, publish on exit.
    always_comb begin
        addr_d    = addr_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        acc_ovf_d = acc_ovf_q;
        sum_d     = sum_q;
        ovf_d     = ovf_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    addr_d    = base;
                    cnt_d     = len;
                    acc_d     = '0;
                    acc_ovf_d = 1'b0;
                    if (len == '0) begin
                        sum_d = '0;
                        ovf_d = 1'b0;
                    end
                end
            end
            RUN: begin
                acc_d     = acc_ext[ACC_W-1:0];
                acc_ovf_d = acc_ovf_q | acc_ext[ACC_W];
                addr_d    = addr_q + ADDR_W'(1);
                cnt_d     = cnt_q - ADDR_W'(1);
                if (last_word) begin
                    sum_d = acc_ext[ACC_W-1:0];
                    ovf_d = acc_ovf_q | acc_ext[ACC_W];
                end
            end
            default: ;
        endcase
    end

    // Outputs decoded from state and result registers.
    always_comb begin
        busy     = (state_q == RUN);
        done     = (state_q == DONE);
        sum      = sum_q;
        overflow = ovf_q;
    end

endmodule

// File: tb/tb_mem_accumulator.sv
// Directed + randomized bench: a 16-bit build and an 8-bit build share the
// same stimulus and memory image; results come from a plain-arithmetic model.
module tb_mem_accumulator;

    logic        clock;
    logic        reset;
    logic        start;
    logic [7:0]  base;
    logic [7:0]  len;
    logic        busy16, done16, ovf16;
    logic [15:0] sum16;
    logic        busy8, done8, ovf8;
    logic [7:0]  sum8;

    int total;
    int bad;

    logic [31:0] mdl [256];

    mem_accumulator dut16 (
        .clock(clock), .reset(reset), .start(start), .base(base), .len(len),
        .busy(busy16), .done(done16), .sum(sum16), .overflow(ovf16)
    );

    mem_accumulator #(.ACC_W(8)) dut8 (
        .clock(clock), .reset(reset), .start(start), .base(base), .len(len),
        .busy(busy8), .done(done8), .sum(sum8), .overflow(ovf8)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input int a, input logic [31:0] v);
        mdl[a & 255]       = v;
        dut16.mem[a & 255] = v;
        dut8.mem[a & 255]  = v;
    endtask

    // Reference: total of low bytes; a carry leaves ACC_W iff the total
    // reaches 2^ACC_W, since partial sums only grow.
    function automatic int ref_total(input int b, input int l);
        int t;
        t = 0;
        for (int k = 0; k < l; k++) t += int'(mdl[(b + k) & 255][7:0]);
        return t;
    endfunction

    // Issue start, then check busy/done every cycle through E(len+1).
    // inject >= 0 re-asserts start (base=0, len=1) during that cycle.
    task automatic run(input int b, input int l, input int inject);
        int t;
        t = ref_total(b, l);
        @(negedge clock);
        start = 1'b1;
        base  = 8'(b);
        len   = 8'(l);
        for (int i = 0; i <= l + 1; i++) begin
            @(posedge clock);
            @(negedge clock);
            chk("busy16", 32'(busy16), 32'(i < l));
            chk("done16", 32'(done16), 32'(i == l));
            chk("busy8",  32'(busy8),  32'(i < l));
            chk("done8",  32'(done8),  32'(i == l));
            if (i == l) begin
                chk("sum16", 32'(sum16), 32'(t % 65536));
                chk("ovf16", 32'(ovf16), 32'(t >= 65536));
                chk("sum8",  32'(sum8),  32'(t % 256));
                chk("ovf8",  32'(ovf8),  32'(t >= 256));
            end
            if (i == inject && i <= l) begin
                start = 1'b1;
                base  = 8'd0;
                len   = 8'd1;
            end else begin
                start = 1'b0;
            end
        end
        chk("hold_sum16", 32'(sum16), 32'(t % 65536));
        chk("hold_sum8",  32'(sum8),  32'(t % 256));
    endtask

    initial begin
        int b;
        int l;
        total = 0;
        bad   = 0;
        reset = 1'b1;
        start = 1'b0;
        base  = 8'd0;
        len   = 8'd0;
        for (int a = 0; a < 256; a++) wr(a, $urandom);

        repeat (2) @(posedge clock);
        @(negedge clock);
        chk("rst_busy", 32'(busy16), 32'd0);
        chk("rst_done", 32'(done16), 32'd0);
        chk("rst_sum",  32'(sum16),  32'd0);
        chk("rst_ovf",  32'(ovf16),  32'd0);
        chk("rst_sum8", 32'(sum8),   32'd0);
        reset = 1'b0;

        // basic sum
        wr(4, 32'h01); wr(5, 32'h02); wr(6, 32'h03); wr(7, 32'h04);
        run(4, 4, -1);
        chk("basic_const", 32'(sum16), 32'h000A);

        // upper bits ignored, address wrap
        wr(254, 32'hFFFF_FF10); wr(255, 32'h20); wr(0, 32'h30);
        run(254, 3, -1);
        chk("wrap_const", 32'(sum16), 32'h0060);

        // zero length
        run(9, 0, -1);

        // start while busy ignored, result held afterwards
        run(4, 4, 1);
        repeat (3) begin
            @(negedge clock);
            chk("idle_hold", 32'(sum16), 32'h000A);
            chk("idle_done", 32'(done16), 32'd0);
        end

        // reset mid-run
        @(negedge clock);
        start = 1'b1; base = 8'd20; len = 8'd10;
        @(posedge clock);
        @(negedge clock);
        start = 1'b0;
        @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        chk("mrst_busy", 32'(busy16), 32'd0);
        chk("mrst_done", 32'(done16), 32'd0);
        chk("mrst_sum",  32'(sum16),  32'd0);
        chk("mrst_ovf",  32'(ovf16),  32'd0);
        chk("mrst_sum8", 32'(sum8),   32'd0);
        reset = 1'b0;
        run(30, 2, -1);

        // 8-bit overflow then clear
        wr(0, 32'hFF); wr(1, 32'h02); wr(2, 32'h01);
        run(0, 2, -1);
        chk("ovf8_sum",  32'(sum8), 32'h01);
        chk("ovf8_flag", 32'(ovf8), 32'd1);
        run(2, 1, -1);
        chk("ovf8_clr", 32'(ovf8), 32'd0);

        // randomized runs over random memory
        for (int a = 0; a < 256; a++) wr(a, $urandom);
        for (int r = 0; r < 10; r++) begin
            b = int'($urandom_range(0, 255));
            l = int'($urandom_range(0, 40));
            run(b, l, (r % 3 == 0) ? int'($urandom_range(0, 5)) : -1);
        end

        // longest run with all-ones operands
        for (int a = 0; a < 256; a++) wr(a, {$urandom_range(0, 16'hFFFF), 16'h00FF});
        run(17, 255, -1);
        chk("max_sum16", 32'(sum16), 32'hFE01);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
